// File: rtl/uart_autobaud.sv
// uart_autobaud: generates the 16x oversampling tick (clk16) for uart_core.
// The tick divisor is either measured from a received 0x55 sync character
// (auto mode) or taken directly from man_div_i (manual mode).
module uart_autobaud #(
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_sn_i,
  input  logic             start_cal_i,
  input  logic             use_manual_i,
  input  logic [DIV_W-1:0] man_div_i,
  output logic             clk16_o,
  output logic             locked_o,
  output logic             cal_busy_o,
  output logic             cal_err_o,
  output logic [DIV_W-1:0] div_out_o
);

  // The measurement spans 8 bit times = 128 ticks, so the counter needs
  // 7 bits beyond the divisor width to hold the largest legal divisor.
  localparam int MW = DIV_W + 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    MEASURE,
    DONE,
    ERR
  } state_t;

  state_t           state_q;
  logic             rxMeta_q;
  logic             rxSync_q;
  logic             rxPrev_q;
  logic             fallEdge;
  logic [MW-1:0]    measCnt_q;
  logic [2:0]       edgeCnt_q;
  logic             locked_q;
  logic             calBusy_q;
  logic             calErr_q;
  logic [DIV_W-1:0] div_q;
  logic [MW-1:0]    roundSum;
  logic [DIV_W-1:0] calDiv;
  logic             divOk;

  logic             tickEn;
  logic [DIV_W-1:0] activeDiv;
  logic [DIV_W-1:0] reloadVal;
  logic [DIV_W-1:0] tcnt_q;
  logic [DIV_W-1:0] tcnt_d;
  logic             clk16_q;
  logic             clk16_d;

  // Bring the asynchronous RX line into the clock domain and keep one older
  // sample so falling edges can be detected on synchronized data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_sn_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign fallEdge = rxPrev_q & ~rxSync_q;

  // Rounded divisor: N counts 128 ticks, so add half a tick-group before
  // dropping 7 bits. Wrap-around of the sum only affects bits above the
  // divisor width, which are discarded anyway.
  assign roundSum = measCnt_q + MW'(64);
  assign calDiv   = DIV_W'(roundSum >> 7);
  assign divOk    = (calDiv >= DIV_W'(MIN_DIV));

  // Calibration FSM; start_cal overrides every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      measCnt_q <= '0;
      edgeCnt_q <= '0;
      locked_q  <= 1'b0;
      calBusy_q <= 1'b0;
      calErr_q  <= 1'b0;
      div_q     <= '0;
    end else if (start_cal_i) begin
      state_q   <= WAIT_START;
      measCnt_q <= '0;
      edgeCnt_q <= '0;
      locked_q  <= 1'b0;
      calBusy_q <= 1'b1;
      calErr_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_START: begin
          if (fallEdge) begin
            state_q   <= MEASURE;
            measCnt_q <= MW'(1);
            edgeCnt_q <= 3'd1;
          end
        end
        MEASURE: begin
          if (fallEdge && (edgeCnt_q == 3'd4)) begin
            edgeCnt_q <= 3'd5;
            calBusy_q <= 1'b0;
            if (divOk) begin
              div_q    <= calDiv;
              locked_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              calErr_q <= 1'b1;
              state_q  <= ERR;
            end
          end else begin
            if (fallEdge) begin
              edgeCnt_q <= edgeCnt_q + 3'd1;
            end
            if (&measCnt_q) begin
              calBusy_q <= 1'b0;
              calErr_q  <= 1'b1;
              state_q   <= ERR;
            end else begin
              measCnt_q <= measCnt_q + MW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tick generator next state: reload from the active divisor only when the
  // down-counter expires, so divisor or mode changes never cut a period short.
  always_comb begin
    tickEn    = use_manual_i | locked_q;
    activeDiv = use_manual_i ? man_div_i : div_q;
    reloadVal = (activeDiv <= DIV_W'(1)) ? '0 : (activeDiv - DIV_W'(1));
    tcnt_d    = tcnt_q;
    clk16_d   = 1'b0;
    if (!tickEn) begin
      tcnt_d = '0;
    end else if (tcnt_q == '0) begin
      clk16_d = 1'b1;
      tcnt_d  = reloadVal;
    end else begin
      tcnt_d = tcnt_q - DIV_W'(1);
    end
  end

  // Tick generator registers; clk16 is registered so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      clk16_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      clk16_q <= clk16_d;
    end
  end

  assign clk16_o    = clk16_q;
  assign locked_o   = locked_q;
  assign cal_busy_o = calBusy_q;
  assign cal_err_o  = calErr_q;
  assign div_out_o  = div_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: randomized self-checking bench for uart_autobaud.
// Expected divisors come from the 0x55 timing rule: the five falling edges
// span 8 bit times, so N = 8 * clocks-per-bit and D = (N + 64) >> 7.
module tb_uart_autobaud;

  localparam int DIV_W   = 16;
  localparam int MIN_DIV = 4;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             rx         = 1'b1;
  logic             startCal   = 1'b0;
  logic             useManual  = 1'b0;
  logic [DIV_W-1:0] manDiv     = '0;
  logic             clk16;
  logic             locked;
  logic             calBusy;
  logic             calErr;
  logic [DIV_W-1:0] divOut;

  logic             rx4        = 1'b1;
  logic             start4     = 1'b0;
  logic             useManual4 = 1'b0;
  logic [3:0]       manDiv4    = '0;
  logic             clk16_4;
  logic             locked4;
  logic             calBusy4;
  logic             calErr4;
  logic [3:0]       divOut4;

  int checks    = 0;
  int failures  = 0;
  int modelDiv  = 0;

  uart_autobaud #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .rx_sn_i      (rx),
    .start_cal_i  (startCal),
    .use_manual_i (useManual),
    .man_div_i    (manDiv),
    .clk16_o      (clk16),
    .locked_o     (locked),
    .cal_busy_o   (calBusy),
    .cal_err_o    (calErr),
    .div_out_o    (divOut)
  );

  // Narrow instance so the measurement-counter timeout is reachable quickly.
  uart_autobaud #(.DIV_W(4), .MIN_DIV(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .rx_sn_i      (rx4),
    .start_cal_i  (start4),
    .use_manual_i (useManual4),
    .man_div_i    (manDiv4),
    .clk16_o      (clk16_4),
    .locked_o     (locked4),
    .cal_busy_o   (calBusy4),
    .cal_err_o    (calErr4),
    .div_out_o    (divOut4)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStartCal();
    startCal = 1'b1;
    tick(1);
    startCal = 1'b0;
  endtask

  task automatic cyclesToTick(input int bound, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (clk16 !== 1'b1 && n < bound);
    if (clk16 !== 1'b1) n = -1;
  endtask

  task automatic measurePeriod(input int bound, output int p);
    int n;
    cyclesToTick(bound, n);
    if (n < 0) p = -1;
    else cyclesToTick(bound, p);
  endtask

  task automatic countTicks(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (clk16 === 1'b1) c++;
    end
  endtask

  // Drive the first nBits bit times of an 8N1 0x55 frame (start bit, data
  // LSB first, stop bit), which alternates 0,1,0,1,... then return to idle.
  task automatic applyStimulus(input int bitClk, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      rx = (i % 2 == 1);
      tick(bitClk);
    end
    rx = 1'b1;
  endtask

  task automatic runCal(input int bitClk, input string tag);
    int expDiv;
    bit expErr;
    int n;
    int p;
    int c;
    expDiv = ((8 * bitClk + 64) >> 7) % 65536;
    expErr = (expDiv < MIN_DIV);
    pulseStartCal();
    checkOutput({tag, ".busyStart"}, calBusy, 1);
    checkOutput({tag, ".lockedStart"}, locked, 0);
    tick($urandom_range(1, 20));
    applyStimulus(bitClk, 10);
    n = 0;
    while (!(locked || calErr) && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput({tag, ".finished"}, (locked || calErr), 1);
    checkOutput({tag, ".busyEnd"}, calBusy, 0);
    if (expErr) begin
      checkOutput({tag, ".err"}, calErr, 1);
      checkOutput({tag, ".locked"}, locked, 0);
      checkOutput({tag, ".divKept"}, divOut, modelDiv);
      countTicks(64, c);
      checkOutput({tag, ".noTicks"}, c, 0);
    end else begin
      modelDiv = expDiv;
      checkOutput({tag, ".err"}, calErr, 0);
      checkOutput({tag, ".locked"}, locked, 1);
      checkOutput({tag, ".div"}, divOut, expDiv);
      for (int k = 0; k < 3; k++) begin
        measurePeriod(4 * expDiv + 8, p);
        checkOutput({tag, ".period"}, p, expDiv);
      end
    end
  endtask

  initial begin
    int d;
    int p;
    int n;
    int c;

    // Reset state, both during and just after reset.
    tick(3);
    checkOutput("rst.clk16", clk16, 0);
    checkOutput("rst.locked", locked, 0);
    checkOutput("rst.busy", calBusy, 0);
    checkOutput("rst.err", calErr, 0);
    checkOutput("rst.div", divOut, 0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle.clk16", clk16, 0);
    checkOutput("idle.locked", locked, 0);

    // Manual mode with random divisors, unlocked.
    useManual = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      manDiv = DIV_W'(d);
      tick(30);
      measurePeriod(40, p);
      checkOutput("manual.period", p, (d <= 1) ? 1 : d);
    end

    // Divisor change mid-period finishes the current period first.
    manDiv = 16'd5;
    tick(20);
    cyclesToTick(20, n);
    tick(2);
    manDiv = 16'd3;
    cyclesToTick(20, n);
    checkOutput("manual.curPeriod", n + 2, 5);
    cyclesToTick(20, n);
    checkOutput("manual.newPeriod", n, 3);

    // Auto mode while unlocked: no ticks at all.
    useManual = 1'b0;
    tick(2);
    countTicks(64, c);
    checkOutput("auto.unlockedNoTicks", c, 0);

    // Directed calibrations, then randomized bit rates.
    runCal(128, "cal128");
    runCal(100, "cal100");
    runCal(16, "calFast");
    for (int i = 0; i < 4; i++) begin
      runCal($urandom_range(20, 300), "calRand");
    end

    // Restart in the middle of a measurement.
    pulseStartCal();
    tick(4);
    applyStimulus(128, 5);
    runCal(128, "restart");

    // Asynchronous reset in the middle of a frame.
    pulseStartCal();
    tick(3);
    applyStimulus(64, 5);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRst.busy", calBusy, 0);
    checkOutput("midRst.locked", locked, 0);
    checkOutput("midRst.err", calErr, 0);
    checkOutput("midRst.clk16", clk16, 0);
    checkOutput("midRst.div", divOut, 0);
    modelDiv = 0;
    tick(3);
    rst = 1'b0;
    tick(3);
    runCal(100, "afterRst");

    // Timeout on the narrow instance: one falling edge, then line held low.
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(5);
    rx4 = 1'b0;
    n = 0;
    while (!calErr4 && n < 2200) begin
      tick(1);
      n++;
    end
    checkOutput("timeout.err", calErr4, 1);
    checkOutput("timeout.busy", calBusy4, 0);
    checkOutput("timeout.locked", locked4, 0);
    checkOutput("timeout.window", (n >= 2045 && n <= 2055), 1);
    checkOutput("timeout.div", divOut4, 0);
    rx4 = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
